// File: rtl/pll_lock_ctrl.sv
// rPLL reset sequencer: PLL reset pulse, lock filter/timeout, domain reset.
// Optional lock-loss counter output enabled by PLL_LOCK_LOSS_CNT_EN.
module pll_lock_ctrl #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_FILT_CYC    = 64,
  parameter int LOCK_TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY        = 3,
  parameter int DOMAIN_RST_CYC   = 8
) (
  input  logic clkin,
  input  logic reset_n,
  input  logic pll_lock,
  input  logic restart,
  output logic pll_reset,
  output logic sys_rst_n,
  output logic ready,
  output logic fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0] state
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int RW = $clog2(RST_PULSE_CYC + 1);
  localparam int FW = $clog2(LOCK_FILT_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int HW = $clog2(DOMAIN_RST_CYC + 1);
  localparam int CW = $clog2(MAX_RETRY + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_PULSE_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DOMAIN_RST_CYC - 1);
  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PRST = 3'd0,
    ST_WAIT = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } st_e;

  st_e           state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] to_q, to_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] retry_q, retry_d, retry_inc;
  logic          sync1_q, lock_s_q;
  logic          attempt_fail;
  logic          pll_reset_q, sys_rst_n_q, ready_q, fail_q;

  // Raw lock is asynchronous to clkin.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    filt_d       = filt_q;
    to_d         = to_q;
    hold_d       = hold_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    retry_inc    = (retry_q == RETRY_MAX) ? retry_q
                                          : retry_q + CW'(1);
    unique case (state_q)
      ST_PRST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT: begin
        to_d   = to_q + TW'(1);
        filt_d = lock_s_q ? filt_q + FW'(1) : '0;
        // Acceptance wins over a same-cycle timeout.
        if (lock_s_q && (filt_q == FILT_LAST)) begin
          state_d = ST_HOLD;
        end else if (to_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s_q) begin
          attempt_fail = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          attempt_fail = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PRST;
      end
    endcase

    if (attempt_fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PRST;
    end

    if (restart) begin
      state_d = ST_PRST;
      retry_d = '0;
    end

    // Every counter starts from zero in each newly entered state.
    if (restart || (state_d != state_q)) begin
      rst_cnt_d = '0;
      filt_d    = '0;
      to_d      = '0;
      hold_d    = '0;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PRST;
      rst_cnt_q   <= '0;
      filt_q      <= '0;
      to_q        <= '0;
      hold_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      filt_q      <= filt_d;
      to_q        <= to_d;
      hold_q      <= hold_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_PRST) || (state_d == ST_FAIL);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else if ((state_q == ST_RUN) && !lock_s_q && !restart
                 && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Sequencer for the on-chip rPLL: drives the PLL reset and filters its lock output.
- Generates a clean, delayed system reset for logic clocked by the PLL outputs.
- Runs on the free-running board reference clock that also feeds the PLL input. It recovers from lock loss and lock timeout by re-resetting the PLL, up to a retry limit, then reports failure.

Parameters:
- RST_PULSE_CYC, 16: cycles pll_reset is held high per reset attempt (min 1).
- LOCK_FILT_CYC, 64: consecutive cycles synchronised lock must stay high before it is accepted (min 1).
- LOCK_TIMEOUT_CYC, 65535: cycles allowed in WAIT_LOCK before an attempt is declared failed (must exceed LOCK_FILT_CYC).
- MAX_RETRY, 3: failed attempts allowed (timeouts plus RUN-state lock losses) before entering FAIL.
- DOMAIN_RST_CYC, 8: cycles between lock acceptance and sys_rst_n release (min 1).

Ports:
- clkin, input, 1: reference clock, free-running.
- reset_n, input, 1: asynchronous active-low reset.
- pll_lock, input, 1: raw PLL lock, asynchronous to clkin.
- restart, input, 1: single-cycle pulse; clears the retry count and restarts the sequence.
- pll_reset, output, 1: active-high reset to the PLL.
- sys_rst_n, output, 1: active-low reset for the PLL clock domains.
- ready, output, 1: high while in RUN.
- fail, output, 1: high while in FAIL.
- retry_cnt, output, 2: failed attempts so far, saturating at MAX_RETRY; width is $clog2(MAX_RETRY+1), 2 at the default.
- state, output, 3: current state encoding, for debug.

Behaviour:
- Async reset values: pll_reset=1, sys_rst_n=0, ready=0, fail=0, retry_cnt=0, state=PRST. All counters clear.
- pll_lock passes through a 2-flop synchroniser (lock_s). Its latency of 2 cycles is counted inside the filter and timeout windows.
- State encodings: PRST=0, WAIT_LOCK=1, HOLD=2, RUN=3, FAIL=4.
- PRST:
  - pll_reset=1, sys_rst_n=0.
  - After RST_PULSE_CYC cycles -> WAIT_LOCK.
  - Both the filter counter and the timeout counter clear on entry.
- WAIT_LOCK:
  - pll_reset=0. The timeout counter increments every cycle.
  - The filter counter increments while lock_s=1 and clears to 0 on any cycle lock_s=0.
  - Filter count reaches LOCK_FILT_CYC -> HOLD.
  - Else timeout count reaches LOCK_TIMEOUT_CYC -> failed attempt.
  - If both conditions occur in the same cycle, acceptance wins.
- Failed attempt:
  - retry_cnt increments (saturating).
  - If the new value equals MAX_RETRY -> FAIL; otherwise -> PRST.
- HOLD:
  - sys_rst_n stays 0.
  - Counts DOMAIN_RST_CYC cycles, then -> RUN.
  - lock_s=0 during HOLD -> failed attempt.
- RUN:
  - ready=1, and sys_rst_n=1 registered on entry.
  - retry_cnt is not cleared on success; it is sticky until restart or reset.
  - lock_s=0 for one cycle: next cycle sys_rst_n=0 and ready=0, and this counts as a failed attempt (-> PRST or FAIL).
- FAIL:
  - pll_reset=1, sys_rst_n=0, fail=1.
  - Holds until restart.
- restart:
  - Accepted in any state: next state PRST, retry_cnt=0, fail=0, sys_rst_n=0, ready=0.
  - restart has priority over every other transition in the same cycle, including a simultaneous lock loss or timeout.
- Counters:
  - Each counter is sized $clog2(param+1), counts to its parameter and compares by equality.
  - No counter wraps, since each one clears on state entry.
- All outputs are registered, with no combinational path from pll_lock or restart to any output.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- When defined: adds output loss_cnt [7:0], cleared by reset_n only, not by restart.
  - Increments by 1 on each RUN->lock-loss event and saturates at 255.
  - Timeouts and HOLD-state losses are not counted.
- When undefined: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_FILT_CYC=8, LOCK_TIMEOUT_CYC=100, MAX_RETRY=2, DOMAIN_RST_CYC=4.
1. Clean lock: release reset_n, then raise pll_lock 10 cycles after pll_reset falls and hold it -> pll_reset high exactly 4 cycles; sys_rst_n rises 2+8+4 cycles (±1 registration) after pll_lock rises; ready=1, retry_cnt=0.
2. Lock glitch during filter: pll_lock high 5 cycles, low 1 cycle, then high -> the filter restarts; acceptance occurs 8 cycles after the second rise plus sync latency, with no retry counted.
3. Timeout to FAIL: pll_lock held 0 -> two attempts of 4-cycle pll_reset then 100 cycles wait; retry_cnt 1 then 2; fail=1, pll_reset=1 stays asserted; a restart pulse clears fail and retry_cnt and pll_reset pulses again.
4. Loss in RUN: reach RUN, drop pll_lock for 1 cycle -> sys_rst_n low within 3 cycles of the drop, state=PRST, retry_cnt=1; relock -> RUN again with retry_cnt=1 (with PLL_LOCK_LOSS_CNT_EN: loss_cnt=1).
5. Simultaneous events: assert restart in the same cycle lock_s falls in RUN -> state=PRST and retry_cnt=0, not 1.
6. Async reset mid-HOLD: pulse reset_n low for half a cycle -> outputs immediately take reset values (pll_reset=1, sys_rst_n=0) and the sequence restarts from PRST.
